// File: rtl/mcycle_ctrl.sv
// Multi-cycle sequencer for the RV32I core: steps each instruction through
// fetch/decode/exec/mem/writeback and runs the imem/dmem valid-ready handshakes.
module mcycle_ctrl #(
    parameter int CNT_W   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       op,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic [2:0]       branch,
    input  logic             ill_inst,
    input  logic             br_taken,
    output logic             imem_valid,
    input  logic             imem_ready,
    output logic             dmem_valid,
    output logic             dmem_wen,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             alu_we,
    output logic             mdr_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic [1:0]       trap,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    // state  | meaning
    // IDLE   | after reset, one cycle before the first fetch
    // FETCH  | instruction fetch handshake, wait counter running
    // DECODE | decoder fields settle, illegal/ebreak detection
    // EXEC   | ALU result latched, branch compare captured
    // MEM    | load/store handshake, wait counter running
    // WB     | register file write and PC update
    // HALT   | stopped until reset, trap code held
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [1:0] TRAP_ENV = 2'b00;
    localparam logic [1:0] TRAP_ILL = 2'b01;
    localparam logic [1:0] TRAP_BUS = 2'b10;

    localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [2:0]  state, state_nxt;
    logic [1:0]  trap_q, trap_nxt;
    logic [15:0] wait_cnt;
    logic        br_q;
    logic        wait_last;
    logic        is_mem_op;
    logic        waiting;

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign is_mem_op = (op == 5'b00000) || (op == 5'b01000);
    assign waiting   = ((state == S_FETCH) || (state == S_MEM)) && (state_nxt == state);

    // A ready in the final wait cycle is checked first, so it still completes.
    always_comb begin
        state_nxt = state;
        trap_nxt  = trap_q;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    state_nxt = S_DECODE;
                end else if (wait_last) begin
                    state_nxt = S_HALT;
                    trap_nxt  = TRAP_BUS;
                end
            end
            S_DECODE: begin
                if (ill_inst) begin
                    state_nxt = S_HALT;
                    trap_nxt  = TRAP_ILL;
                end else if (op == 5'b11100) begin
                    state_nxt = S_HALT;
                    trap_nxt  = TRAP_ENV;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC:   state_nxt = is_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    state_nxt = S_WB;
                end else if (wait_last) begin
                    state_nxt = S_HALT;
                    trap_nxt  = TRAP_BUS;
                end
            end
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            trap_q      <= 2'b00;
            wait_cnt    <= 16'd0;
            br_q        <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            state    <= state_nxt;
            trap_q   <= trap_nxt;
            wait_cnt <= waiting ? wait_cnt + 16'd1 : 16'd0;
            if (state == S_EXEC) begin
                br_q <= br_taken;
            end
            if ((state != S_IDLE) && (state != S_HALT)) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
            end
            if (state == S_WB) begin
                instret_cnt <= instret_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        imem_valid = (state == S_FETCH);
        ir_we      = (state == S_FETCH) && imem_ready;
        dmem_valid = (state == S_MEM);
        dmem_wen   = (state == S_MEM) && mem_write;
        mdr_we     = (state == S_MEM) && dmem_ready && !mem_write;
        alu_we     = (state == S_EXEC);
        reg_we     = (state == S_WB) && reg_write;
        pc_we      = (state == S_WB);
        halted     = (state == S_HALT);
        trap       = trap_q;
        state_o    = state;
        pc_src     = 2'b00;
        if (state == S_WB) begin
            if ((branch == 3'b001) || (branch[2] && br_q)) begin
                pc_src = 2'b01;
            end else if (branch == 3'b010) begin
                pc_src = 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: per-cycle expected output vectors are
// queued as stimulus is driven and popped when the DUT cycle is observed.
module tb_mcycle_ctrl;

    localparam int CNT_W = 64;
    localparam int TO    = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       op;
    logic             reg_write, mem_write, ill_inst, br_taken;
    logic [2:0]       branch;
    logic             imem_valid, imem_ready, dmem_valid, dmem_wen, dmem_ready;
    logic             ir_we, alu_we, mdr_we, reg_we, pc_we, halted;
    logic [1:0]       pc_src, trap;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    mcycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .reg_write(reg_write),
        .mem_write(mem_write), .branch(branch), .ill_inst(ill_inst),
        .br_taken(br_taken), .imem_valid(imem_valid), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_wen(dmem_wen), .dmem_ready(dmem_ready),
        .ir_we(ir_we), .alu_we(alu_we), .mdr_we(mdr_we), .reg_we(reg_we),
        .pc_we(pc_we), .pc_src(pc_src), .halted(halted), .trap(trap),
        .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] exp_q[$];
    logic [CNT_W-1:0] exp_cyc, exp_ret;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {state, imem_valid, ir_we, dmem_valid, dmem_wen, mdr_we, alu_we, reg_we, pc_we, pc_src, halted, trap}
    function automatic logic [15:0] mk(input logic [2:0] st, input logic iv, irw, dv, wen, mdr,
                                       alu, rwe, pcwe, input logic [1:0] ps,
                                       input logic hl, input logic [1:0] tr);
        return {st, iv, irw, dv, wen, mdr, alu, rwe, pcwe, ps, hl, tr};
    endfunction

    function automatic logic [15:0] obs();
        return {state_o, imem_valid, ir_we, dmem_valid, dmem_wen, mdr_we, alu_we,
                reg_we, pc_we, pc_src, halted, trap};
    endfunction

    task automatic cyc(input string tag);
        logic [15:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 128'(exp_q.size()), 128'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 128'(obs()), 128'(e));
            chk({tag, "_cnt"}, {cycle_cnt, instret_cnt}, {exp_cyc, exp_ret});
            if (e[15:13] != 3'd0 && e[15:13] != 3'd6) exp_cyc++;
            if (e[15:13] == 3'd5) exp_ret++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [15:0] e);
        exp_q.push_back(e);
        cyc(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cyc = '0;
        exp_ret = '0;
        exp_q.delete();
        step("idle", mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    endtask

    task automatic set_dec(input logic [4:0] o, input logic rw, mw, input logic [2:0] br, input logic ill);
        op = o; reg_write = rw; mem_write = mw; branch = br; ill_inst = ill;
    endtask

    task automatic fetch(input int fw);
        for (int i = 0; i < fw; i++) begin
            imem_ready = 1'b0;
            step("fetch_wait", mk(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        end
        imem_ready = 1'b1;
        step("fetch", mk(3'd1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        imem_ready = 1'b0;
    endtask

    task automatic run_instr(input string nm, input logic [4:0] o, input logic rw, mw,
                             input logic [2:0] br, input logic ill, tk,
                             input int fw, dw, input logic [1:0] ps);
        set_dec(o, rw, mw, br, ill);
        br_taken = !tk;
        fetch(fw);
        step({nm, "_dec"}, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        if (ill || o == 5'b11100) return;
        br_taken = tk;
        step({nm, "_exec"}, mk(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00));
        br_taken = !tk;
        if (o == 5'b00000 || o == 5'b01000) begin
            for (int i = 0; i < dw; i++) begin
                dmem_ready = 1'b0;
                step({nm, "_memw"}, mk(3'd4, 0, 0, 1, mw, 0, 0, 0, 0, 2'b00, 0, 2'b00));
            end
            dmem_ready = 1'b1;
            step({nm, "_mem"}, mk(3'd4, 0, 0, 1, mw, !mw, 0, 0, 0, 2'b00, 0, 2'b00));
            dmem_ready = 1'b0;
        end
        step({nm, "_wb"}, mk(3'd5, 0, 0, 0, 0, 0, 0, rw, 1, ps, 0, 2'b00));
    endtask

    task automatic halt_hold(input string nm, input logic [1:0] tr, input int n);
        for (int i = 0; i < n; i++) begin
            imem_ready = i[0];
            dmem_ready = !i[0];
            step(nm, mk(3'd6, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, tr));
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_dec(5'b00100, 1'b0, 1'b0, 3'b000, 1'b0);
        br_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 128'(obs()), 128'd0);
        chk("rst_cnt", {cycle_cnt, instret_cnt}, 128'd0);
        do_reset();

        for (int i = 0; i < 3; i++)
            run_instr("addi", 5'b00100, 1, 0, 3'b000, 0, 0, 0, 0, 2'b00);
        chk("cycle_after3", 128'(cycle_cnt), 128'd12);
        chk("instret_after3", 128'(instret_cnt), 128'd3);

        run_instr("lw", 5'b00000, 1, 0, 3'b000, 0, 0, 0, 3, 2'b00);
        chk("cycle_after_lw", 128'(cycle_cnt), 128'd20);

        run_instr("beq", 5'b11000, 0, 0, 3'b100, 0, 1, 0, 0, 2'b01);
        run_instr("bne", 5'b11000, 0, 0, 3'b101, 0, 0, 0, 0, 2'b00);
        run_instr("jalr", 5'b11001, 1, 0, 3'b010, 0, 0, 0, 0, 2'b10);
        run_instr("jal", 5'b11011, 1, 0, 3'b001, 0, 1, 0, 0, 2'b01);
        run_instr("sw", 5'b01000, 0, 1, 3'b000, 0, 0, 0, 0, 2'b00);
        run_instr("addi_fw2", 5'b00100, 1, 0, 3'b000, 0, 0, 2, 0, 2'b00);
        run_instr("ready_wins", 5'b00100, 1, 0, 3'b000, 0, 0, TO - 1, 0, 2'b00);

        // reset while a load is stalled in MEM
        set_dec(5'b00000, 1'b1, 1'b0, 3'b000, 1'b0);
        fetch(0);
        step("rstmem_dec", mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        step("rstmem_exec", mk(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00));
        for (int i = 0; i < 2; i++)
            step("rstmem_memw", mk(3'd4, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        do_reset();
        chk("rstmem_cycle", 128'(cycle_cnt), 128'd0);
        run_instr("post_rst", 5'b00100, 1, 0, 3'b000, 0, 0, 0, 0, 2'b00);

        run_instr("ill", 5'b00100, 1, 0, 3'b000, 1, 0, 0, 0, 2'b00);
        halt_hold("halt_ill", 2'b01, 4);
        do_reset();

        run_instr("ebreak", 5'b11100, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00);
        halt_hold("halt_env", 2'b00, 3);
        do_reset();

        set_dec(5'b00100, 1'b1, 1'b0, 3'b000, 1'b0);
        imem_ready = 1'b0;
        for (int i = 0; i < TO; i++)
            step("ftimeout_wait", mk(3'd1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        halt_hold("halt_fbus", 2'b10, 3);
        chk("ftimeout_cycle", 128'(cycle_cnt), 128'(TO));
        do_reset();

        set_dec(5'b00000, 1'b1, 1'b0, 3'b000, 1'b0);
        fetch(0);
        step("mtimeout_dec", mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        step("mtimeout_exec", mk(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00));
        for (int i = 0; i < TO; i++)
            step("mtimeout_wait", mk(3'd4, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
        halt_hold("halt_mbus", 2'b10, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
